// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writers; counts committed writes.
// Latency: Gnt is combinational in cycle N; WEn/WAddr/WData are registered and valid in N+1.
// Backpressure: one grant per cycle. Hold or Rst suppresses all grants; losers keep Req high and retry.
module regfile_wr_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 32,
  parameter int ZERO_DISCARD = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*5-1:0] Addr,
  input  logic [NREQ*DW-1:0] Data,
  input  logic              Hold,
  output logic [NREQ-1:0]   Gnt,
  output logic [31:0]       WEn,
  output logic [4:0]        WAddr,
  output logic [DW-1:0]     WData,
  output logic [15:0]       WCnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  logic [PW:0]     sum;
  logic            gnt_vld;
  logic [NREQ-1:0] gnt;
  logic [4:0]      sel_addr;
  logic [DW-1:0]   sel_data;
  logic [31:0]     wen_nxt;

  // Search ascends from ptr with wrap; only Req, Hold, Rst and ptr feed the grant.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    sum     = '0;
    if (!Rst && !Hold) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
        cand = sum[PW-1:0];
        if (!gnt_vld && Req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  assign Gnt = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_addr = Addr[5*k +: 5];
        sel_data = Data[DW*k +: DW];
      end
    end
  end

  // Address 0 is hard-wired on the register file, so its write is accepted but dropped here.
  always_comb begin
    wen_nxt = '0;
    if (gnt_vld && !((ZERO_DISCARD != 0) && (sel_addr == 5'd0)))
      wen_nxt = 32'd1 << sel_addr;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr   <= '0;
      WEn   <= '0;
      WAddr <= '0;
      WData <= '0;
      WCnt  <= '0;
    end else begin
      WEn <= wen_nxt;
      if (gnt_vld) begin
        WAddr <= sel_addr;
        WData <= sel_data;
        ptr   <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
      end
      if (wen_nxt != '0) WCnt <= WCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector bench for regfile_wr_arbiter (NREQ=4, DW=32, ZERO_DISCARD=1).
module tb_regfile_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [19:0]  addr;
  logic [127:0] data;
  logic         hold;
  logic [3:0]   gnt;
  logic [31:0]  wen;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [15:0]  wcnt;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.NREQ(4), .DW(32), .ZERO_DISCARD(1)) dut (
    .Clk(clk), .Rst(rst), .Req(req), .Addr(addr), .Data(data), .Hold(hold),
    .Gnt(gnt), .WEn(wen), .WAddr(waddr), .WData(wdata), .WCnt(wcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic [19:0] addr;
    logic [31:0] dbase;
    logic [3:0]  gnt;
    logic [31:0] wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] wcnt;
  } vec_t;

  vec_t tv[27];

  function automatic logic [19:0] a4(input int a3, input int a2, input int a1, input int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic vec_t v(input logic r, input logic h, input logic [3:0] rq,
                             input logic [19:0] ad, input logic [31:0] db,
                             input logic [3:0] g, input logic [31:0] we,
                             input logic [4:0] wa, input logic [31:0] wd,
                             input logic [15:0] wc);
    vec_t t;
    t.rst = r; t.hold = h; t.req = rq; t.addr = ad; t.dbase = db;
    t.gnt = g; t.wen = we; t.waddr = wa; t.wdata = wd; t.wcnt = wc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic [3:0] rq,
                       input logic [19:0] ad, input logic [31:0] db);
    rst  = r;
    hold = h;
    req  = rq;
    addr = ad;
    data = {db + 32'd3, db + 32'd2, db + 32'd1, db};
  endtask

  initial begin
    // reset with pending requests
    tv[0]  = v(1, 0, 4'b1111, a4(4,3,2,1),     32'h1000_0000, 4'b0000, 32'h0,         5'd0,  32'h0,         16'd0);
    tv[1]  = v(1, 0, 4'b1111, a4(4,3,2,1),     32'h1000_0000, 4'b0000, 32'h0,         5'd0,  32'h0,         16'd0);
    tv[2]  = v(0, 0, 4'b1111, a4(4,3,2,1),     32'h1000_0000, 4'b0001, 32'h0000_0002, 5'd1,  32'h1000_0000, 16'd1);
    tv[3]  = v(0, 0, 4'b0000, a4(4,3,2,1),     32'h1000_0000, 4'b0000, 32'h0,         5'd1,  32'h1000_0000, 16'd1);
    // single write
    tv[4]  = v(0, 0, 4'b0100, a4(0,19,0,0),    32'hDEAD_BEED, 4'b0100, 32'h0008_0000, 5'd19, 32'hDEAD_BEEF, 16'd2);
    tv[5]  = v(0, 0, 4'b0000, a4(0,19,0,0),    32'hDEAD_BEED, 4'b0000, 32'h0,         5'd19, 32'hDEAD_BEEF, 16'd2);
    // bring ptr to 0, then full rotation
    tv[6]  = v(0, 0, 4'b1000, a4(13,12,11,10), 32'h2000_0000, 4'b1000, 32'h0000_2000, 5'd13, 32'h2000_0003, 16'd3);
    tv[7]  = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b0001, 32'h0000_0400, 5'd10, 32'h2000_0000, 16'd4);
    tv[8]  = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b0010, 32'h0000_0800, 5'd11, 32'h2000_0001, 16'd5);
    tv[9]  = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b0100, 32'h0000_1000, 5'd12, 32'h2000_0002, 16'd6);
    tv[10] = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b1000, 32'h0000_2000, 5'd13, 32'h2000_0003, 16'd7);
    tv[11] = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b0001, 32'h0000_0400, 5'd10, 32'h2000_0000, 16'd8);
    tv[12] = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b0010, 32'h0000_0800, 5'd11, 32'h2000_0001, 16'd9);
    tv[13] = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b0100, 32'h0000_1000, 5'd12, 32'h2000_0002, 16'd10);
    tv[14] = v(0, 0, 4'b1111, a4(13,12,11,10), 32'h2000_0000, 4'b1000, 32'h0000_2000, 5'd13, 32'h2000_0003, 16'd11);
    // address 0 discard, then prove ptr moved to 2
    tv[15] = v(0, 0, 4'b0010, a4(0,0,0,0),     32'h0000_1233, 4'b0010, 32'h0,         5'd0,  32'h0000_1234, 16'd11);
    tv[16] = v(0, 0, 4'b0110, a4(0,21,20,0),   32'h3000_0000, 4'b0100, 32'h0020_0000, 5'd21, 32'h3000_0002, 16'd12);
    // hold mid-stream
    tv[17] = v(0, 0, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b1000, 32'h0200_0000, 5'd25, 32'h4000_0003, 16'd13);
    tv[18] = v(0, 0, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b0010, 32'h0100_0000, 5'd24, 32'h4000_0001, 16'd14);
    tv[19] = v(0, 1, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b0000, 32'h0,         5'd24, 32'h4000_0001, 16'd14);
    tv[20] = v(0, 1, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b0000, 32'h0,         5'd24, 32'h4000_0001, 16'd14);
    tv[21] = v(0, 1, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b0000, 32'h0,         5'd24, 32'h4000_0001, 16'd14);
    tv[22] = v(0, 0, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b1000, 32'h0200_0000, 5'd25, 32'h4000_0003, 16'd15);
    tv[23] = v(0, 0, 4'b1010, a4(25,0,24,0),   32'h4000_0000, 4'b0010, 32'h0100_0000, 5'd24, 32'h4000_0001, 16'd16);
    // mid-stream reset clears ptr (ptr 2 would pick 3 below)
    tv[24] = v(1, 0, 4'b1111, a4(25,0,24,0),   32'h4000_0000, 4'b0000, 32'h0,         5'd0,  32'h0,         16'd0);
    tv[25] = v(0, 0, 4'b1010, a4(31,0,30,0),   32'h5000_0000, 4'b0010, 32'h4000_0000, 5'd30, 32'h5000_0001, 16'd1);
    tv[26] = v(0, 0, 4'b1010, a4(31,0,30,0),   32'h5000_0000, 4'b1000, 32'h8000_0000, 5'd31, 32'h5000_0003, 16'd2);

    for (int i = 0; i < 27; i++) begin
      drive(tv[i].rst, tv[i].hold, tv[i].req, tv[i].addr, tv[i].dbase);
      #1;
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wen", i), wen, tv[i].wen);
      check($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tv[i].waddr));
      check($sformatf("v%0d_wdata", i), wdata, tv[i].wdata);
      check($sformatf("v%0d_wcnt", i), 32'(wcnt), 32'(tv[i].wcnt));
    end

    // counter wrap: WCnt=2 here; 65533 more commits reach 0xFFFF
    drive(0, 0, 4'b0001, a4(0,0,0,1), 32'h6000_0000);
    repeat (65533) @(posedge clk);
    #1;
    check("wrap_pre_cnt", 32'(wcnt), 32'h0000_FFFF);
    check("wrap_pre_wen", wen, 32'h0000_0002);
    check("wrap_pre_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    check("wrap_cnt", 32'(wcnt), 32'h0);
    check("wrap_wen", wen, 32'h0000_0002);
    check("wrap_wdata", wdata, 32'h6000_0000);
    drive(0, 0, 4'b0000, a4(0,0,0,1), 32'h6000_0000);
    #1;
    check("idle_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    check("idle_wen", wen, 32'h0);
    check("idle_cnt", 32'(wcnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
